store_commit_queue: RTL and testbench
=====================================

// Module: store_commit_queue
// PURPOSE
//  Post-commit store queue between reorder_buffer store-commit port and the data cache.
//  Absorbs committed stores and acks the ROB early; drains stores to the cache in FIFO order.
//  Arbitrates the single data-cache port with load requests from the load/store buffer.
//  Stalls loads that hit a pending store word (no forwarding).
// PARAMETERS
//  SQ_DEPTH  4  committed-store entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  st_write     in   1   ROB mem_write: store held valid (level)
//  st_new       in   1   ROB new_store: first cycle of a store (pulse)
//  st_addr      in   32  word-aligned store address
//  st_wdata     in   32  lane-aligned store data
//  st_byte_en   in   4   store byte enables
//  st_resp      out  1   ack to ROB (ROB mem_resp); 1-cycle pulse
//  flush        in   1   ROB mispredict flush (affects loads only)
//  ld_req       in   1   load request from load/store buffer (level, held until ld_resp)
//  ld_addr      in   32  word-aligned load address
//  ld_resp      out  1   load data valid; 1-cycle pulse
//  ld_rdata     out  32  load data; valid with ld_resp
//  dc_read      out  1   data-cache read
//  dc_write     out  1   data-cache write
//  dc_addr      out  32  data-cache address
//  dc_wdata     out  32  data-cache write data
//  dc_byte_en   out  4   data-cache byte enables (4'b1111 on reads)
//  dc_rdata     in   32  data-cache read data
//  dc_resp      in   1   data-cache response
//  sq_empty     out  1   no pending stores (and no store in flight)
// BEHAVIOUR
//  Reset: queue empty, head=tail=0, count=0, state IDLE, st_pend=0.
//   All outputs 0 except sq_empty=1.
//  Enqueue:
//   - Store accepted on any cycle where st_write && (st_new || st_pend) && count<SQ_DEPTH.
//   - Capture st_addr/wdata/byte_en at tail; tail wraps SQ_DEPTH-1 -> 0.
//   - st_resp pulses the cycle after acceptance.
//  Full:
//   - st_new while full sets st_pend.
//   - Store is accepted the first cycle count<SQ_DEPTH, including the same cycle a drain frees an entry.
//   - st_pend clears on acceptance.
//   - ROB holds st_* stable meanwhile.
//  Count:
//   - Enqueue+dequeue same cycle -> count unchanged.
//   - count is $clog2(SQ_DEPTH)+1 bits; never exceeds SQ_DEPTH.
//  States:
//   - IDLE -> LOAD : ld_req && !ld_hit && !flush && (count<SQ_DEPTH || count==0).
//   - IDLE -> STORE: count>0 otherwise.
//   - LOAD/STORE -> IDLE on dc_resp.
//   - Loads win over draining unless the queue is full or the load hits.
//  ld_hit: ld_addr[31:2] equals addr[31:2] of any valid entry.
//  Request signals:
//   - STORE drives dc_write with the head entry.
//   - LOAD drives dc_read, dc_addr=ld_addr latched at issue.
//   - Request is held constant until dc_resp; issued the cycle after leaving IDLE.
//  STORE completion: dc_resp dequeues head; head wraps.
//  LOAD completion:
//   - dc_resp pulses ld_resp with ld_rdata=dc_rdata, same cycle (combinational pass-through).
//   - flush while in LOAD sets ld_kill; the cache access completes, ld_resp is suppressed, ld_kill clears.
//   - flush in IDLE blocks load issue that cycle.
//   - flush never removes queued stores (already committed).
//  sq_empty = (count==0) && state!=STORE.
//  Reset mid-operation: rst dominates; in-flight cache transaction is abandoned, queue cleared.
// TESTING
//  1. Store 0x100/0xDEADBEEF/be 1111 into empty queue:
//     - st_resp 1 cycle later.
//     - dc_write with same values; sq_empty=1 after dc_resp.
//  2. Five back-to-back stores with dc_resp held low (SQ_DEPTH=4):
//     - fifth st_resp withheld until first dc_resp; FIFO drain order preserved.
//  3. 2 stores queued to 0x200, 0x300; ld_req 0x300:
//     - load stalls until the 0x300 store drains; then dc_read 0x300, ld_resp with dc_rdata.
//  4. ld_req 0x400 with 1 non-matching store queued:
//     - load issued first (dc_read), then store drains.
//  5. flush during LOAD:
//     - dc_read held until dc_resp; ld_resp stays 0; queued store still written afterwards.
//  6. rst asserted with 3 queued stores mid-STORE:
//     - next cycle dc_write=0, sq_empty=1, st_resp=0.

Source files
------------

// File: rtl/store_commit_queue.sv
// store_commit_queue: post-commit store FIFO sharing the data-cache port with loads
module store_commit_queue #(
    parameter int SQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_write,
    input  logic        st_new,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_byte_en,
    output logic        st_resp,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_resp,
    output logic [31:0] ld_rdata,
    output logic        dc_read,
    output logic        dc_write,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_byte_en,
    input  logic [31:0] dc_rdata,
    input  logic        dc_resp,
    output logic        sq_empty
);
    localparam int AW = $clog2(SQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(SQ_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;
    logic [31:0] addr_q [SQ_DEPTH];
    logic [31:0] wdata_q [SQ_DEPTH];
    logic [3:0] be_q [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic st_pend_q, st_resp_q, ld_kill_q;
    state_t state_q;
    logic enq, deq, ld_hit, go_load;
    assign deq = state_q == STORE && dc_resp;
    assign enq = st_write && (st_new || st_pend_q) && (count_q != FULL || deq);
    assign go_load = ld_req && !ld_hit && !flush && count_q != FULL;
    assign st_resp = st_resp_q;
    assign ld_resp = state_q == LOAD && dc_resp && !ld_kill_q && !flush;
    assign ld_rdata = ld_resp ? dc_rdata : '0;
    assign sq_empty = count_q == '0 && state_q != STORE;
    // a load is blocked while any queued store targets the same word
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++)
            ld_hit = ld_hit | (valid_q[i] && addr_q[i][31:2] == ld_addr[31:2]);
    end
    // next occupancy; a freed head slot may be refilled in the same cycle
    always_comb begin
        valid_d = valid_q;
        if (deq) valid_d[head_q] = 1'b0;
        if (enq) valid_d[tail_q] = 1'b1;
        count_d = count_q + CW'(enq) - CW'(deq);
    end
    // queue pointers, pending-store flag and ROB ack
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            st_pend_q <= 1'b0;
            st_resp_q <= 1'b0;
        end else begin
            head_q <= deq ? head_q + AW'(1) : head_q;
            tail_q <= enq ? tail_q + AW'(1) : tail_q;
            count_q <= count_d;
            valid_q <= valid_d;
            st_pend_q <= enq ? 1'b0 : st_pend_q | (st_write && st_new);
            st_resp_q <= enq;
        end
    end
    // entry payload storage, qualified by valid_q
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            wdata_q[tail_q] <= st_wdata;
            be_q[tail_q] <= st_byte_en;
        end
    end
    // cache-port arbiter with registered request outputs held until dc_resp
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_kill_q <= 1'b0;
            dc_read <= 1'b0;
            dc_write <= 1'b0;
            dc_addr <= '0;
            dc_wdata <= '0;
            dc_byte_en <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_load) begin
                        state_q <= LOAD;
                        dc_read <= 1'b1;
                        dc_addr <= ld_addr;
                        dc_wdata <= '0;
                        dc_byte_en <= 4'b1111;
                    end else if (count_q != '0) begin
                        state_q <= STORE;
                        dc_write <= 1'b1;
                        dc_addr <= addr_q[head_q];
                        dc_wdata <= wdata_q[head_q];
                        dc_byte_en <= be_q[head_q];
                    end
                end
                LOAD: begin
                    if (flush) ld_kill_q <= 1'b1;
                    if (dc_resp) begin
                        state_q <= IDLE;
                        ld_kill_q <= 1'b0;
                        dc_read <= 1'b0;
                        dc_addr <= '0;
                        dc_byte_en <= '0;
                    end
                end
                STORE: begin
                    if (dc_resp) begin
                        state_q <= IDLE;
                        dc_write <= 1'b0;
                        dc_addr <= '0;
                        dc_wdata <= '0;
                        dc_byte_en <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_commit_queue.sv
// tb_store_commit_queue: directed checks of store queueing, draining and load arbitration
module tb_store_commit_queue;
    logic clk = 1'b0;
    logic rst, st_write, st_new, flush, ld_req, dc_resp;
    logic [31:0] st_addr, st_wdata, ld_addr, dc_rdata;
    logic [3:0] st_byte_en;
    logic st_resp, ld_resp, dc_read, dc_write, sq_empty;
    logic [31:0] ld_rdata, dc_addr, dc_wdata;
    logic [3:0] dc_byte_en;
    int total = 0;
    int bad = 0;
    store_commit_queue #(.SQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .st_write(st_write), .st_new(st_new),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_byte_en(st_byte_en),
        .st_resp(st_resp), .flush(flush), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_resp(ld_resp), .ld_rdata(ld_rdata), .dc_read(dc_read),
        .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_byte_en(dc_byte_en), .dc_rdata(dc_rdata), .dc_resp(dc_resp),
        .sq_empty(sq_empty)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_write = 1'b1;
        st_new = 1'b1;
        st_addr = a;
        st_wdata = d;
        st_byte_en = be;
        tick();
        chk("st_resp_put", st_resp, 1);
        st_write = 1'b0;
        st_new = 1'b0;
    endtask
    task automatic drain(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        tick();
        chk("drain_write", dc_write, 1);
        chk("drain_read", dc_read, 0);
        chk("drain_addr", dc_addr, a);
        chk("drain_wdata", dc_wdata, d);
        chk("drain_be", {28'd0, dc_byte_en}, {28'd0, be});
        dc_resp = 1'b1;
        tick();
        dc_resp = 1'b0;
        chk("drain_done", dc_write, 0);
    endtask
    initial begin
        rst = 1'b1; st_write = 0; st_new = 0; flush = 0; ld_req = 0; dc_resp = 0;
        st_addr = 0; st_wdata = 0; st_byte_en = 0; ld_addr = 0; dc_rdata = 0;
        tick();
        tick();
        chk("rst_empty", sq_empty, 1);
        chk("rst_st_resp", st_resp, 0);
        chk("rst_write", dc_write, 0);
        chk("rst_read", dc_read, 0);
        chk("rst_ld_resp", ld_resp, 0);
        chk("rst_addr", dc_addr, 0);
        rst = 1'b0;
        tick();
        put(32'h100, 32'hDEADBEEF, 4'hF);
        chk("t1_idle", dc_write, 0);
        drain(32'h100, 32'hDEADBEEF, 4'hF);
        chk("t1_empty", sq_empty, 1);
        for (int i = 0; i < 4; i++) put(32'h1000 + 32'(i * 4), 32'h11110000 + 32'(i), 4'hF);
        st_write = 1'b1;
        st_new = 1'b1;
        st_addr = 32'h1010;
        st_wdata = 32'h11110004;
        tick();
        chk("t2_full_withheld", st_resp, 0);
        st_new = 1'b0;
        tick();
        chk("t2_pend_withheld", st_resp, 0);
        chk("t2_head_addr", dc_addr, 32'h1000);
        chk("t2_head_write", dc_write, 1);
        dc_resp = 1'b1;
        tick();
        dc_resp = 1'b0;
        chk("t2_fifth_ack", st_resp, 1);
        st_write = 1'b0;
        for (int i = 1; i < 5; i++) drain(32'h1000 + 32'(i * 4), 32'h11110000 + 32'(i), 4'hF);
        chk("t2_empty", sq_empty, 1);
        put(32'h200, 32'hA2, 4'h3);
        put(32'h300, 32'hA3, 4'hC);
        ld_req = 1'b1;
        ld_addr = 32'h300;
        drain(32'h200, 32'hA2, 4'h3);
        drain(32'h300, 32'hA3, 4'hC);
        tick();
        chk("t3_read", dc_read, 1);
        chk("t3_addr", dc_addr, 32'h300);
        chk("t3_be", {28'd0, dc_byte_en}, 32'hF);
        dc_resp = 1'b1;
        dc_rdata = 32'hCAFEF00D;
        #1;
        chk("t3_ld_resp", ld_resp, 1);
        chk("t3_rdata", ld_rdata, 32'hCAFEF00D);
        tick();
        dc_resp = 1'b0;
        ld_req = 1'b0;
        chk("t3_read_done", dc_read, 0);
        ld_req = 1'b1;
        ld_addr = 32'h400;
        put(32'h500, 32'hB5, 4'hF);
        chk("t4_read_first", dc_read, 1);
        chk("t4_no_write", dc_write, 0);
        chk("t4_addr", dc_addr, 32'h400);
        dc_resp = 1'b1;
        dc_rdata = 32'h12345678;
        #1;
        chk("t4_ld_resp", ld_resp, 1);
        chk("t4_rdata", ld_rdata, 32'h12345678);
        tick();
        dc_resp = 1'b0;
        ld_req = 1'b0;
        drain(32'h500, 32'hB5, 4'hF);
        ld_req = 1'b1;
        ld_addr = 32'h600;
        put(32'h700, 32'hC7, 4'h1);
        chk("t5_read", dc_read, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ld_req = 1'b0;
        chk("t5_read_held", dc_read, 1);
        chk("t5_addr_held", dc_addr, 32'h600);
        tick();
        chk("t5_read_held2", dc_read, 1);
        dc_resp = 1'b1;
        dc_rdata = 32'h55AA55AA;
        #1;
        chk("t5_ld_killed", ld_resp, 0);
        tick();
        dc_resp = 1'b0;
        chk("t5_read_done", dc_read, 0);
        drain(32'h700, 32'hC7, 4'h1);
        chk("t5_empty", sq_empty, 1);
        ld_req = 1'b1;
        ld_addr = 32'h800;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_block", dc_read, 0);
        tick();
        chk("idle_flush_issue", dc_read, 1);
        dc_resp = 1'b1;
        dc_rdata = 32'h0BADF00D;
        #1;
        chk("idle_flush_ld_resp", ld_resp, 1);
        tick();
        dc_resp = 1'b0;
        ld_req = 1'b0;
        put(32'h900, 32'h90, 4'hF);
        put(32'h904, 32'h94, 4'hF);
        put(32'h908, 32'h98, 4'hF);
        chk("t6_mid_store", dc_write, 1);
        chk("t6_not_empty", sq_empty, 0);
        rst = 1'b1;
        tick();
        chk("t6_write", dc_write, 0);
        chk("t6_empty", sq_empty, 1);
        chk("t6_st_resp", st_resp, 0);
        rst = 1'b0;
        tick();
        chk("t6_cleared", dc_write, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
